// File: rtl/demux8_router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux8_router_pkg
//  Description : Shared types and constants for the 1-to-8 registered data
//                router: buffer occupancy states, destination count and
//                default widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package demux8_router_pkg;

   // Number of destinations served by the router
   localparam int DEST_COUNT         = 8;

   // Default widths used by the router top level
   localparam int DATA_WIDTH_DEFAULT = 32;
   localparam int SEL_WIDTH_DEFAULT  = 3;
   localparam int CNT_WIDTH_DEFAULT  = 16;

   // Buffer occupancy: nothing held, output register held, output + skid held
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_state_e;

endpackage : demux8_router_pkg
`default_nettype wire

// File: rtl/demux8_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : demux8_sat_counter
//  Description : CNT_WIDTH-bit up counter that sticks at all-ones instead of
//                wrapping, with a synchronous clear that overrides increment.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux8_sat_counter #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] count
);

   logic [CNT_WIDTH-1:0] count_q;
   logic [CNT_WIDTH-1:0] count_d;

   // Next count: step by one unless already saturated
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {CNT_WIDTH{1'b1}})) begin
         count_d = count_q + CNT_WIDTH'(1);
      end
   end

   // Count register with synchronous clear
   always_ff @(posedge clk) begin
      if (clr) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule : demux8_sat_counter
`default_nettype wire

// File: rtl/demux8_router.sv
`default_nettype none
// ============================================================================
//  Module      : demux8_router
//  Description : Registered 1-to-8 data router. Accepts {selector, word} over
//                valid/ready and offers it to one of eight destinations, each
//                with its own valid/ready pair. An output register plus a
//                skid register give full throughput with a registered
//                in_ready. Words leave strictly in acceptance order.
//                Optional per-destination saturating transfer counters are
//                built when DEMUX8_ROUTER_COUNT_EN is defined; otherwise
//                count_output is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux8_router
   import demux8_router_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
   parameter int SEL_WIDTH  = SEL_WIDTH_DEFAULT,
   parameter int CNT_WIDTH  = CNT_WIDTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [SEL_WIDTH-1:0]  selector,
   input  logic [DATA_WIDTH-1:0] data_input,
   output logic [DEST_COUNT-1:0] out_valid,
   input  logic [DEST_COUNT-1:0] out_ready,
   output logic [DATA_WIDTH-1:0] data_output,
   input  logic [SEL_WIDTH-1:0]  count_sel,
   output logic [CNT_WIDTH-1:0]  count_output
);

   occ_state_e            state_q,     state_d;
   logic [SEL_WIDTH-1:0]  out_sel_q,   out_sel_d;
   logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
   logic [SEL_WIDTH-1:0]  skid_sel_q,  skid_sel_d;
   logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;

   logic w_in_fire;
   logic w_out_fire;

   // Ready depends only on registered occupancy, held low during reset
   assign in_ready   = (state_q != OCC_TWO) && !reset;
   assign w_in_fire  = in_valid && in_ready;
   // Only the ready bit of the currently addressed destination matters
   assign w_out_fire = (state_q != OCC_EMPTY) && out_ready[out_sel_q];

   assign out_valid   = (state_q != OCC_EMPTY) ? (DEST_COUNT'(1) << out_sel_q) : '0;
   assign data_output = out_data_q;

   // Occupancy transitions and slot loading
   always_comb begin
      state_d     = state_q;
      out_sel_d   = out_sel_q;
      out_data_d  = out_data_q;
      skid_sel_d  = skid_sel_q;
      skid_data_d = skid_data_q;
      case (state_q)
         OCC_EMPTY: begin
            if (w_in_fire) begin
               state_d    = OCC_ONE;
               out_sel_d  = selector;
               out_data_d = data_input;
            end
         end
         OCC_ONE: begin
            if (w_in_fire && w_out_fire) begin
               // Departing word is replaced directly by the arriving one
               out_sel_d  = selector;
               out_data_d = data_input;
            end else if (w_in_fire) begin
               state_d     = OCC_TWO;
               skid_sel_d  = selector;
               skid_data_d = data_input;
            end else if (w_out_fire) begin
               state_d = OCC_EMPTY;
            end
         end
         OCC_TWO: begin
            // in_ready is low here, so only a departure can happen
            if (w_out_fire) begin
               state_d    = OCC_ONE;
               out_sel_d  = skid_sel_q;
               out_data_d = skid_data_q;
            end
         end
         default: begin
            state_d = OCC_EMPTY;
         end
      endcase
   end

   // Buffer registers; reset discards both slots
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= OCC_EMPTY;
         out_sel_q   <= '0;
         out_data_q  <= '0;
         skid_sel_q  <= '0;
         skid_data_q <= '0;
      end else begin
         state_q     <= state_d;
         out_sel_q   <= out_sel_d;
         out_data_q  <= out_data_d;
         skid_sel_q  <= skid_sel_d;
         skid_data_q <= skid_data_d;
      end
   end

`ifdef DEMUX8_ROUTER_COUNT_EN
   logic [CNT_WIDTH-1:0] dest_count [DEST_COUNT];

   for (genvar d = 0; d < DEST_COUNT; d++) begin : g_dest_cnt
      logic inc;
      assign inc = w_out_fire && (out_sel_q == SEL_WIDTH'(d));

      demux8_sat_counter #(
         .CNT_WIDTH (CNT_WIDTH)
      ) u_cnt (
         .clk   (clk),
         .clr   (reset),
         .inc   (inc),
         .count (dest_count[d])
      );
   end

   assign count_output = dest_count[count_sel];
`else
   logic unused_count_sel;
   assign unused_count_sel = ^count_sel;
   assign count_output     = '0;
`endif

endmodule : demux8_router
`default_nettype wire
